// File: rtl/sram_bridge.sv
// Two-port (fetch / memory-stage) bridge onto a 16-bit asynchronous SRAM.
// Each 32-bit word is split into an even (low) and odd (high) halfword access.
module sram_bridge #(
  parameter int ADDR_W = 18,
  parameter int WAIT   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_ack,
  input  logic              mem_en,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [15:0]       ram_data,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic              ram_ce_n,
  output logic              ram_ub_n,
  output logic              ram_lb_n
);

  typedef enum logic [2:0] {S_IDLE, S_R0, S_R1, S_W0, S_W1, S_W2, S_W3, S_ACK} state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  state_t              r_state, w_state_next;
  logic [2:0]          r_cnt;
  logic                w_wait_done;
  logic [ADDR_W-1:0]   r_addr, w_base, w_even, w_odd;
  logic [31:0]         r_wdata, w_wdata;
  logic                r_grant_mem, w_grant_mem;
  logic [15:0]         r_rd_lo;
  logic [31:0]         r_if_data, r_mem_rdata;
  logic                r_if_ack, r_mem_ack;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_we_n, r_oe_n, r_drive;
  logic [15:0]         r_bus;

  assign w_wait_done = (r_cnt == WAIT_CNT);

  always_comb begin
    w_state_next = r_state;
    w_base       = r_addr;
    w_wdata      = r_wdata;
    w_grant_mem  = r_grant_mem;
    case (r_state)
      S_IDLE: begin
        // Memory stage has strict priority over fetch.
        if (mem_en) begin
          w_state_next = mem_rw ? S_W0 : S_R0;
          w_base       = mem_addr;
          w_wdata      = mem_wdata;
          w_grant_mem  = 1'b1;
        end else if (if_en) begin
          w_state_next = S_R0;
          w_base       = if_addr;
          w_grant_mem  = 1'b0;
        end
      end
      S_R0:    if (w_wait_done) w_state_next = S_R1;
      S_R1:    if (w_wait_done) w_state_next = S_ACK;
      S_W0:    if (w_wait_done) w_state_next = S_W1;
      S_W1:    w_state_next = S_W2;
      S_W2:    if (w_wait_done) w_state_next = S_W3;
      S_W3:    w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Odd halfword is a bit-0 set, so the top word wraps with no carry.
    w_even = w_base & ~ADDR_W'(1);
    w_odd  = w_base | ADDR_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_grant_mem <= 1'b0;
      r_rd_lo     <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_ram_addr  <= '0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_drive     <= 1'b0;
      r_bus       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= (w_state_next != r_state) ? 3'd0 : r_cnt + 3'd1;
      r_addr      <= w_base;
      r_wdata     <= w_wdata;
      r_grant_mem <= w_grant_mem;

      if (r_state == S_R0 && w_wait_done)
        r_rd_lo <= ram_data;
      if (r_state == S_R1 && w_wait_done) begin
        if (r_grant_mem) r_mem_rdata <= {ram_data, r_rd_lo};
        else             r_if_data   <= {ram_data, r_rd_lo};
      end

      r_if_ack  <= (w_state_next == S_ACK) && !w_grant_mem;
      r_mem_ack <= (w_state_next == S_ACK) &&  w_grant_mem;

      // Pin values are registered from the state being entered.
      r_we_n  <= !(w_state_next == S_W0 || w_state_next == S_W2);
      r_oe_n  <= !(w_state_next == S_R0 || w_state_next == S_R1);
      r_drive <= (w_state_next == S_W0) || (w_state_next == S_W1) ||
                 (w_state_next == S_W2) || (w_state_next == S_W3);
      r_bus   <= (w_state_next == S_W0 || w_state_next == S_W1) ? w_wdata[15:0] : w_wdata[31:16];
      case (w_state_next)
        S_R0, S_W0, S_W1: r_ram_addr <= w_even;
        S_R1, S_W2, S_W3: r_ram_addr <= w_odd;
        default: ;
      endcase
    end
  end

  assign if_data   = r_if_data;
  assign if_ack    = r_if_ack;
  assign mem_rdata = r_mem_rdata;
  assign mem_ack   = r_mem_ack;
  assign ram_addr  = r_ram_addr;
  assign ram_we_n  = r_we_n;
  assign ram_oe_n  = r_oe_n;
  assign ram_data  = r_drive ? r_bus : 16'hzzzz;
  assign ram_ce_n  = 1'b0;
  assign ram_ub_n  = 1'b0;
  assign ram_lb_n  = 1'b0;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: two instances (WAIT=0 and WAIT=2), each with an
// asynchronous SRAM model that writes on the rising edge of we_n.
module tb_sram_bridge;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        if_en0 = 1'b0, mem_en0 = 1'b0, mem_en1 = 1'b0, if_en1 = 1'b0;
  logic        mem_rw = 1'b0;
  logic [17:0] if_addr = '0, mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        probe = 1'b0;

  logic [31:0] if_data0, mem_rdata0, if_data1, mem_rdata1;
  logic        if_ack0, mem_ack0, if_ack1, mem_ack1;
  logic [17:0] addr0, addr1;
  wire  [15:0] bus0, bus1;
  logic        we_n0, oe_n0, ce_n0, ub_n0, lb_n0;
  logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;

  sram_bridge #(.ADDR_W(18), .WAIT(0)) dut (
    .clock(clock), .reset(reset),
    .if_en(if_en0), .if_addr(if_addr), .if_data(if_data0), .if_ack(if_ack0),
    .mem_en(mem_en0), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata0), .mem_ack(mem_ack0),
    .ram_addr(addr0), .ram_data(bus0), .ram_we_n(we_n0), .ram_oe_n(oe_n0),
    .ram_ce_n(ce_n0), .ram_ub_n(ub_n0), .ram_lb_n(lb_n0)
  );

  sram_bridge #(.ADDR_W(18), .WAIT(2)) dut_w2 (
    .clock(clock), .reset(reset),
    .if_en(if_en1), .if_addr(if_addr), .if_data(if_data1), .if_ack(if_ack1),
    .mem_en(mem_en1), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata1), .mem_ack(mem_ack1),
    .ram_addr(addr1), .ram_data(bus1), .ram_we_n(we_n1), .ram_oe_n(oe_n1),
    .ram_ce_n(ce_n1), .ram_ub_n(ub_n1), .ram_lb_n(lb_n1)
  );

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  assign bus0 = (!oe_n0 && we_n0) ? mem0[addr0] : 16'hzzzz;
  assign bus0 = probe ? 16'hA5A5 : 16'hzzzz;
  assign bus1 = (!oe_n1 && we_n1) ? mem1[addr1] : 16'hzzzz;

  always @(posedge we_n0) if (reset) mem0[addr0] = bus0;
  always @(posedge we_n1) if (reset) mem1[addr1] = bus1;

  int n_total = 0, n_bad = 0;
  int n_oe_low = 0, n_oe_low1 = 0, n_we_fall = 0;
  int n_if_ack = 0, n_mem_ack = 0, n_both = 0;
  logic [17:0] oe_addrs [$];

  always @(negedge clock) begin
    if (!oe_n0) begin n_oe_low++; oe_addrs.push_back(addr0); end
    if (!oe_n1) n_oe_low1++;
    if (if_ack0) n_if_ack++;
    if (mem_ack0) n_mem_ack++;
    if (if_ack0 && mem_ack0) n_both++;
  end
  always @(negedge we_n0) if (reset) n_we_fall++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // sel: 0 = fetch on dut, 1 = mem on dut, 2 = mem on dut_w2. k = cycle of ack (0 = timeout).
  task automatic req(input int sel, input logic rw, input logic [17:0] a,
                     input logic [31:0] wd, output int k);
    @(posedge clock); #1;
    mem_rw = rw; mem_addr = a; mem_wdata = wd; if_addr = a;
    case (sel)
      0:       if_en0 = 1'b1;
      1:       mem_en0 = 1'b1;
      default: mem_en1 = 1'b1;
    endcase
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      if ((sel == 0 && if_ack0) || (sel == 1 && mem_ack0) || (sel == 2 && mem_ack1)) begin
        k = i;
        break;
      end
    end
    if_en0 = 1'b0; mem_en0 = 1'b0; mem_en1 = 1'b0;
  endtask

  task automatic check_bus_z(input string tag);
    probe = 1'b1; #1;
    check(tag, {16'h0, bus0}, 32'h0000A5A5);
    probe = 1'b0; #1;
  endtask

  initial begin
    int k, km, ki, b_if, b_mem;
    mem0[18'h10] = 16'hBEEF;  mem0[18'h11] = 16'hDEAD;
    mem0[18'h30] = 16'h3333;  mem0[18'h31] = 16'h4444;
    mem0[18'h50] = 16'h5555;  mem0[18'h51] = 16'h6666;
    mem0[18'h60] = 16'h0000;  mem0[18'h61] = 16'h0000;
    mem0[18'h3FFFE] = 16'hCAFE; mem0[18'h3FFFF] = 16'hF00D;
    mem1[18'h40] = 16'h1111;  mem1[18'h41] = 16'h2222;

    // Reset state
    #22;
    check("rst_we_n", {31'h0, we_n0}, 32'h1);
    check("rst_oe_n", {31'h0, oe_n0}, 32'h1);
    check("rst_addr", {14'h0, addr0}, 32'h0);
    check("rst_acks", {30'h0, if_ack0, mem_ack0}, 32'h0);
    check("rst_if_data", if_data0, 32'h0);
    check("rst_mem_rdata", mem_rdata0, 32'h0);
    check("rst_ce_ub_lb", {29'h0, ce_n0, ub_n0, lb_n0}, 32'h0);
    check_bus_z("rst_bus_z");
    @(negedge clock); reset = 1'b1;

    // Fetch read, WAIT=0
    repeat (2) @(posedge clock);
    n_oe_low = 0;
    req(0, 1'b0, 18'h00010, 32'h0, k);
    check("fetch_lat", k, 3);
    check("fetch_data", if_data0, 32'hDEADBEEF);
    check("fetch_oe_cycles", n_oe_low, 2);
    repeat (3) @(posedge clock); #1;
    check("fetch_hold", if_data0, 32'hDEADBEEF);
    check("fetch_ack_once", n_if_ack, 1);

    // Mem write
    n_we_fall = 0;
    req(1, 1'b1, 18'h00020, 32'h12345678, k);
    check("wr_lat", k, 5);
    check("wr_we_pulses", n_we_fall, 2);
    check("wr_lo", {16'h0, mem0[18'h20]}, 32'h5678);
    check("wr_hi", {16'h0, mem0[18'h21]}, 32'h1234);
    check("wr_rdata_kept", mem_rdata0, 32'h0);
    @(posedge clock); #1;
    check_bus_z("wr_bus_z");

    // Simultaneous requests: mem first, then fetch
    b_if = n_if_ack; b_mem = n_mem_ack; km = 0; ki = 0;
    @(posedge clock); #1;
    mem_en0 = 1'b1; mem_rw = 1'b0; mem_addr = 18'h30; if_en0 = 1'b1; if_addr = 18'h50;
    for (int i = 1; i <= 40 && ki == 0; i++) begin
      @(posedge clock); #1;
      if (mem_ack0 && km == 0) begin
        km = i; mem_en0 = 1'b0;
        check("both_mem_data", mem_rdata0, 32'h44443333);
      end
      if (if_ack0) begin
        ki = i; if_en0 = 1'b0;
        check("both_if_data", if_data0, 32'h66665555);
      end
    end
    mem_en0 = 1'b0; if_en0 = 1'b0;
    check("both_mem_lat", km, 3);
    check("both_if_lat", ki, 7);
    repeat (5) @(posedge clock); #1;
    check("both_mem_acks", n_mem_ack - b_mem, 1);
    check("both_if_acks", n_if_ack - b_if, 1);
    check("no_double_ack", n_both, 0);

    // Reset in the middle of a write (W2)
    @(posedge clock); #1;
    mem_en0 = 1'b1; mem_rw = 1'b1; mem_addr = 18'h60; mem_wdata = 32'hAABBCCDD;
    repeat (3) @(posedge clock); #1;
    check("mid_w2_we_low", {31'h0, we_n0}, 32'h0);
    b_mem = n_mem_ack;
    reset = 1'b0; mem_en0 = 1'b0; #1;
    check("mid_we_n", {31'h0, we_n0}, 32'h1);
    check("mid_oe_n", {31'h0, oe_n0}, 32'h1);
    check("mid_addr", {14'h0, addr0}, 32'h0);
    check("mid_mem_rdata", mem_rdata0, 32'h0);
    check_bus_z("mid_bus_z");
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    repeat (10) @(posedge clock); #1;
    check("mid_no_ack", n_mem_ack - b_mem, 0);
    check("mid_lo_written", {16'h0, mem0[18'h60]}, 32'hCCDD);
    check("mid_hi_untouched", {16'h0, mem0[18'h61]}, 32'h0);
    req(1, 1'b0, 18'h00020, 32'h0, k);
    check("post_rst_lat", k, 3);
    check("post_rst_data", mem_rdata0, 32'h12345678);

    // WAIT=2 read; odd request address, bit 0 ignored
    n_oe_low1 = 0;
    req(2, 1'b0, 18'h00041, 32'h0, k);
    check("w2_lat", k, 7);
    check("w2_data", mem_rdata1, 32'h22221111);
    check("w2_oe_cycles", n_oe_low1, 6);

    // Top-address read
    @(posedge clock);
    oe_addrs.delete();
    req(1, 1'b0, 18'h3FFFF, 32'h0, k);
    check("top_lat", k, 3);
    check("top_data", mem_rdata0, 32'hF00DCAFE);
    check("top_n_addr", oe_addrs.size(), 2);
    if (oe_addrs.size() == 2) begin
      check("top_addr_even", {14'h0, oe_addrs[0]}, 32'h3FFFE);
      check("top_addr_odd", {14'h0, oe_addrs[1]}, 32'h3FFFF);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Sits between the processor's two memory requesters and the external 16-bit asynchronous SRAM.
  - Fetch port: read-only.
  - Memory-stage port: read/write.
- Arbitrates between the two ports and serialises each 32-bit word access into two 16-bit SRAM half-accesses.
- Returns the assembled word with a one-cycle acknowledge pulse on the selected port.
- Owns all SRAM control pins and the tri-state data bus.

Parameters:
- ADDR_W, 18: SRAM halfword address width.
- WAIT, 0: extra wait cycles inserted into each SRAM half-access (0..7).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_en  in  1  fetch read request; held high until if_ack.
- if_addr  in  ADDR_W  fetch halfword address; bit 0 ignored.
- if_data  out  32  fetch read data; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- mem_en  in  1  memory-stage request; held until mem_ack.
- mem_rw  in  1  1=write, 0=read.
- mem_addr  in  ADDR_W  memory-stage halfword address; bit 0 ignored.
- mem_wdata  in  32  memory-stage write data.
- mem_rdata  out  32  memory-stage read data; valid while mem_ack=1.
- mem_ack  out  1  one-cycle memory-stage completion pulse.
- ram_addr  out  ADDR_W  SRAM address.
- ram_data  inout  16  SRAM data bus.
- ram_we_n  out  1  SRAM write enable, active-low.
- ram_oe_n  out  1  SRAM output enable, active-low.
- ram_ce_n  out  1  SRAM chip enable; constant 0.
- ram_ub_n, ram_lb_n  out  1 each  byte masks; constant 0.

Behaviour:
- Outputs are registered except ram_data, which is driven from registered data and a registered drive-enable.
- Reset (reset=0, async, also mid-transaction):
  - State IDLE.
  - ram_we_n=1, ram_oe_n=1, ram_data=Z, ram_addr=0.
  - if_ack=0, mem_ack=0, if_data=0, mem_rdata=0.
  - Any in-flight transaction is abandoned; no ack is ever issued for it.
- Word layout: even halfword {addr[ADDR_W-1:1],0} holds bits [15:0]; odd halfword {addr[ADDR_W-1:1],1} holds bits [31:16].
- States: IDLE, R0, R1, W0, W1, W2, W3, ACK.
- IDLE:
  - If mem_en=1: latch mem_addr, mem_rw and mem_wdata; go to W0 if write, R0 if read; grant=MEM.
  - Else if if_en=1: latch if_addr; go to R0; grant=IF.
  - Strict priority: when both are requested in the same cycle, mem wins.
- R0:
  - ram_addr=even halfword, ram_oe_n=0.
  - Lasts 1+WAIT cycles; ram_data sampled into the low half at the last edge.
  - Then ram_addr advances to odd halfword; go to R1.
- R1: same as R0, sampling the high half; then go to ACK.
- W0:
  - ram_addr=even halfword, bus driven with wdata[15:0], ram_we_n=0.
  - Lasts 1+WAIT cycles; then go to W1.
- W1: ram_we_n=1; address and data held for one cycle (hold time); then go to W2.
- W2: as W0 with odd halfword and wdata[31:16]; then go to W3.
- W3: as W1; then go to ACK.
- The bus is driven only in W0..W3; ram_oe_n=1 in every state except R0/R1.
- ACK:
  - Granted port's ack=1 for exactly this one cycle; read data presented on if_data or mem_rdata.
  - if_data/mem_rdata hold their value after ack until the next read on the same port completes.
  - Next state is IDLE.
- Latency from the request-sampled edge to the ack cycle, WAIT=0: read 3 cycles; write 5 cycles.
- General latency: read 3+2*WAIT; write 5+2*WAIT.
- Requesters drop en on the edge where they see ack; if en is still high in IDLE, a new transaction starts.
- Inputs changing while a transaction is busy are ignored; only the values latched in IDLE are used.
- Address wrap: odd halfword of the top word is {all-ones}; there is no carry into other bits.

Test Plan:
- Reset mid-write: assert reset=0 while the FSM is in W2 → outputs immediately take reset values, ram_data=Z, no mem_ack is issued, and the next request starts cleanly from IDLE.
- Fetch read, WAIT=0, if_addr=0x00010, SRAM model holds [0x10]=0xBEEF and [0x11]=0xDEAD → ram_oe_n low for 2 cycles, if_ack pulses once 3 cycles after the request, if_data=0xDEADBEEF.
- Mem write, mem_addr=0x00020, mem_wdata=0x12345678 → two we_n low pulses; SRAM [0x20]=0x5678 and [0x21]=0x1234; mem_ack 5 cycles after the request; bus Z afterwards.
- Simultaneous if_en and mem_en reads → mem is served first (mem_ack at cycle 3), then fetch (if_ack at cycle 7); data on each port is correct and there is never a double ack.
- WAIT=2 read → each half-access lasts 3 cycles; ack arrives 7 cycles after the request; captured data is correct.
- Top-address read with mem_addr=0x3FFFF → half-accesses go to 0x3FFFE then 0x3FFFF; bit 0 of the request address is ignored.
